// File: rtl/ps2_key_event_ctrl.sv
// PS/2 keyboard front end: synchronise, capture 11-bit frames, fold E0/F0 prefixes into key events, buffer in a FIFO.
// Optional build macro PS2_PARITY_CHECK_EN enables odd-parity checking of received frames.
module ps2_key_event_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 5000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_kb,
   input  logic       data_kb,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_brk,
   output logic [7:0] key_held,
   output logic       frame_err,
   output logic       overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Synchronisers idle high, matching the PS/2 bus idle level, so reset causes no false edge.
   logic [SYNC_STAGES-1:0] clk_sync_reg, data_sync_reg;
   logic                   clk_prev_reg;
   logic                   clk_s, data_s, fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_reg  <= '1;
         data_sync_reg <= '1;
         clk_prev_reg  <= 1'b1;
      end else begin
         clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], clk_kb};
         data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], data_kb};
         clk_prev_reg  <= clk_s;
      end
   end

   assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
   assign data_s = data_sync_reg[SYNC_STAGES-1];
   assign fall   = clk_prev_reg & ~clk_s;

   state_t          state_reg, state_next;
   logic [2:0]      bit_cnt_reg, bit_cnt_next;
   logic [7:0]      shift_reg, shift_next;
   logic [WW-1:0]   wd_reg, wd_next;
   logic            frame_err_reg, err;
   logic            byte_valid;
   logic            par_ok;
`ifdef PS2_PARITY_CHECK_EN
   logic            par_ok_reg, par_ok_next;
   assign par_ok = par_ok_reg;
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         wd_reg        <= '0;
         frame_err_reg <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par_ok_reg    <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         wd_reg        <= wd_next;
         frame_err_reg <= err;
`ifdef PS2_PARITY_CHECK_EN
         par_ok_reg    <= par_ok_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      wd_next      = wd_reg;
      err          = 1'b0;
      byte_valid   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_ok_next  = par_ok_reg;
`endif
      if (!fall) begin
         // Watchdog only runs mid-frame; expiry drops the partial byte.
         if (state_reg != IDLE) begin
            if (wd_reg == WW'(TIMEOUT_CYC - 1)) begin
               state_next = IDLE;
               wd_next    = '0;
               err        = 1'b1;
            end else begin
               wd_next = wd_reg + 1'b1;
            end
         end
      end else begin
         wd_next = '0;
         case (state_reg)
            IDLE: begin
               if (!data_s) begin
                  state_next   = DATA;
                  bit_cnt_next = '0;
               end else begin
                  err = 1'b1;
               end
            end
            DATA: begin
               shift_next   = {data_s, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 1'b1;
               if (bit_cnt_reg == 3'd7) state_next = PARITY;
            end
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_ok_next = ^{shift_reg, data_s};
`endif
               state_next = STOP;
            end
            default: begin
               state_next = IDLE;
               if (data_s && par_ok) byte_valid = 1'b1;
               else                  err        = 1'b1;
            end
         endcase
      end
   end

   assign frame_err = frame_err_reg;

   logic       ext_reg, brk_reg;
   logic [7:0] key_held_reg;
   logic       push;

   assign push = byte_valid && (shift_reg != 8'hE0) && (shift_reg != 8'hF0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_reg      <= 1'b0;
         brk_reg      <= 1'b0;
         key_held_reg <= '0;
      end else if (byte_valid) begin
         if (shift_reg == 8'hE0) begin
            ext_reg <= 1'b1;
         end else if (shift_reg == 8'hF0) begin
            brk_reg <= 1'b1;
         end else begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
            if (!brk_reg)                        key_held_reg <= shift_reg;
            else if (shift_reg == key_held_reg)  key_held_reg <= '0;
         end
      end
   end

   assign key_held = key_held_reg;

   // Event FIFO entry layout: {ext, brk, code}.
   logic [9:0]  mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PW:0]   count_reg;
   logic          full, pop, push_ok;
   logic          overflow_reg;
   logic [9:0]    head;

   assign full    = (count_reg == (PW+1)'(FIFO_DEPTH));
   assign ev_valid = (count_reg != '0);
   assign pop     = ev_valid && ev_ready;
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= {ext_reg, brk_reg, shift_reg};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push_ok && !pop)      count_reg <= count_reg + 1'b1;
         else if (!push_ok && pop) count_reg <= count_reg - 1'b1;
         if (push && !push_ok)     overflow_reg <= 1'b1;
      end
   end

   // Head is gated so the outputs read zero while the FIFO is empty.
   assign head     = ev_valid ? mem[rd_ptr_reg] : '0;
   assign ev_code  = head[7:0];
   assign ev_brk   = head[8];
   assign ev_ext   = head[9];
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: drives PS/2 frames bit by bit and checks events, key_held and error flags.
module tb_ps2_key_event_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_kb = 1'b1;
   logic       data_kb = 1'b1;
   logic       ev_valid, ev_ready;
   logic [7:0] ev_code, key_held;
   logic       ev_ext, ev_brk, frame_err, overflow;

   int errors = 0;
   int checks = 0;
   int err_pulses = 0;
   logic [9:0] evq [$];

   ps2_key_event_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYC(200), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .clk_kb(clk_kb), .data_kb(data_kb),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
      .ev_ext(ev_ext), .ev_brk(ev_brk), .key_held(key_held),
      .frame_err(frame_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Record every accepted event and every cycle frame_err is high.
   always @(negedge clk) begin
      if (ev_valid && ev_ready) evq.push_back({ev_ext, ev_brk, ev_code});
      if (frame_err) err_pulses++;
   end

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish, got running required finished");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic v);
      data_kb = v;
      wait_cyc(10);
      clk_kb = 1'b0;
      wait_cyc(20);
      clk_kb = 1'b1;
      wait_cyc(10);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop_bit);
      logic p;
      p = ~(^b) ^ par_bad;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(p);
      ps2_bit(stop_bit);
      data_kb = 1'b1;
      wait_cyc(10);
   endtask

   task automatic expect_one(input string tag, input logic [9:0] exp);
      logic [9:0] e;
      check({tag, "_count"}, evq.size(), 1);
      e = (evq.size() > 0) ? evq[0] : 10'h3FF;
      check({tag, "_event"}, e, exp);
      evq.delete();
   endtask

   initial begin
      ev_ready = 1'b1;
      wait_cyc(5);
      check("rst_ev_valid", ev_valid, 0);
      check("rst_ev_code", ev_code, 0);
      check("rst_key_held", key_held, 0);
      check("rst_overflow", overflow, 0);
      check("rst_frame_err", frame_err, 0);
      rst = 1'b0;
      wait_cyc(5);

      send_frame(8'h1C, 1'b0, 1'b1);
      expect_one("make_1c", {2'b00, 8'h1C});
      check("held_1c", key_held, 8'h1C);

      send_frame(8'hF0, 1'b0, 1'b1);
      check("no_event_f0", evq.size(), 0);
      send_frame(8'h1C, 1'b0, 1'b1);
      expect_one("break_1c", {2'b01, 8'h1C});
      check("held_cleared", key_held, 8'h00);

      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      expect_one("ext_break_75", {2'b11, 8'h75});
      send_frame(8'h74, 1'b0, 1'b1);
      expect_one("flags_cleared_74", {2'b00, 8'h74});
      check("held_74", key_held, 8'h74);
      check("no_err_so_far", err_pulses, 0);

      send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      check("parity_err", err_pulses, 1);
      check("parity_no_event", evq.size(), 0);
      check("parity_fifo_empty", ev_valid, 0);
      check("parity_held", key_held, 8'h74);
`else
      check("parity_ignored_err", err_pulses, 0);
      expect_one("parity_ignored", {2'b00, 8'h1C});
      check("parity_ignored_held", key_held, 8'h1C);
`endif
      err_pulses = 0;

      send_frame(8'h33, 1'b0, 1'b0);
      check("bad_stop_err", err_pulses, 1);
      check("bad_stop_no_event", evq.size(), 0);
      err_pulses = 0;

      ps2_bit(1'b1);
      wait_cyc(5);
      check("bad_start_err", err_pulses, 1);
      err_pulses = 0;

      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'b1);
      wait_cyc(100);
      check("wd_not_yet", err_pulses, 0);
      wait_cyc(200);
      check("timeout_err", err_pulses, 1);
      check("timeout_no_event", evq.size(), 0);
      err_pulses = 0;
      send_frame(8'h29, 1'b0, 1'b1);
      expect_one("after_timeout_29", {2'b00, 8'h29});
      check("after_timeout_no_err", err_pulses, 0);

      // Reset in the middle of a frame: silent abort.
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      rst = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(300);
      check("midrst_no_err", err_pulses, 0);
      check("midrst_no_event", evq.size(), 0);
      check("midrst_held", key_held, 8'h00);

      ev_ready = 1'b0;
      send_frame(8'h15, 1'b0, 1'b1);
      check("latency_valid", ev_valid, 1);
      send_frame(8'h16, 1'b0, 1'b1);
      send_frame(8'h17, 1'b0, 1'b1);
      send_frame(8'h18, 1'b0, 1'b1);
      check("full_no_overflow", overflow, 0);
      send_frame(8'h19, 1'b0, 1'b1);
      check("overflow_set", overflow, 1);
      check("overflow_held", key_held, 8'h19);
      check("head_stable", ev_code, 8'h15);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain_%0d", i), {ev_valid, ev_code}, {1'b1, 8'h15 + 8'(i)});
         ev_ready = 1'b1;
         wait_cyc(1);
         ev_ready = 1'b0;
      end
      check("drained_empty", ev_valid, 0);
      check("overflow_sticky", overflow, 1);
      check("drain_count", evq.size(), 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
